output_serializer_param: RTL and testbench

Parametrised successor to the output wrapper. It captures NUM_RES result words of RES_W bits each when the compute core signals Done. It buffers up to DEPTH such transactions in a FIFO and streams them onto a BUS_W-bit bus one beat at a time, using a valid/accept handshake. It sits between the divider datapath and the external byte bus.

---
 rtl/output_serializer_param.sv | 148 ++++++++++++++
 tb/tb_output_serializer_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/output_serializer_param.sv
// rtl/output_serializer_param.sv - buffers multi-word results and streams them as bus-width beats
module output_serializer_param #(
    parameter int RES_W   = 16,
    parameter int NUM_RES = 2,
    parameter int BUS_W   = 8,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Done,
    input  logic [NUM_RES*RES_W-1:0] results_in,
    input  logic                     got_data,
    output logic                     ready_for_input,
    output logic [BUS_W-1:0]         Bus_out,
    output logic                     buffer_ready,
    output logic                     empty_buffer,
    output logic                     last_beat,
    output logic                     overflow
);

    localparam int TOT_W  = NUM_RES * RES_W;
    localparam int BEATS  = TOT_W / BUS_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);

    typedef enum logic {S_EMPTY, S_SEND} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [TOT_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [BCNT_W-1:0]   r_beat_cnt;
    logic                r_overflow;

    logic                w_send;
    logic                w_push;
    logic                w_xfer;
    logic                w_pop;
    logic [TOT_W-1:0]    w_head;
    logic [TOT_W-1:0]    w_stream;
    logic [BUS_W-1:0]    w_beats [BEATS];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode; space is judged from the registered count so a pop never frees room for the same cycle's Done
    always_comb begin
        w_push = Done && (r_count < FULL_CNT);
        w_xfer = (r_state == S_SEND) && got_data;
        w_pop  = w_xfer && (r_beat_cnt == LAST_BEAT);
    end

    // Next-state and buffer_ready decode
    always_comb begin
        w_next_state = r_state;
        w_send       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_send = 1'b1;
                if (w_pop && (r_count == CNT_W'(1)) && !w_push) begin
                    w_next_state = S_EMPTY;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= results_in;
        end
    end

    // Pointers, occupancy, beat position and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head     <= ptr_inc(r_head);
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (Done && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Reorder head entry so word0 sits at the top, then slice it into beats, most significant beat first
    always_comb begin
        w_head   = r_mem[r_head];
        w_stream = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            w_stream[(NUM_RES-1-i)*RES_W +: RES_W] = w_head[i*RES_W +: RES_W];
        end
        for (int b = 0; b < BEATS; b++) begin
            w_beats[b] = w_stream[(BEATS-1-b)*BUS_W +: BUS_W];
        end
    end

    // Outputs depend on registered state only
    always_comb begin
        buffer_ready    = w_send;
        Bus_out         = w_send ? w_beats[r_beat_cnt] : '0;
        last_beat       = w_send && (r_beat_cnt == LAST_BEAT);
        empty_buffer    = (r_count == '0);
        ready_for_input = (r_count < FULL_CNT);
        overflow        = r_overflow;
    end

endmodule

// File: tb/tb_output_serializer_param.sv
// tb/tb_output_serializer_param.sv - self-checking bench for output_serializer_param
module tb_output_serializer_param;

    logic        clk;
    logic        rst, done, got;
    logic [31:0] res;
    logic [7:0]  bus;
    logic        rfi, br, empty, last, ovf;

    logic        s_rst, s_done, s_got;
    logic [95:0] s_res;
    logic [15:0] s_bus;
    logic        s_rfi, s_br, s_empty, s_last, s_ovf;

    int checks = 0;
    int errors = 0;

    output_serializer_param dut (
        .clk(clk), .rst(rst), .Done(done), .results_in(res), .got_data(got),
        .ready_for_input(rfi), .Bus_out(bus), .buffer_ready(br),
        .empty_buffer(empty), .last_beat(last), .overflow(ovf)
    );

    output_serializer_param #(.RES_W(32), .NUM_RES(3), .BUS_W(16), .DEPTH(4)) dut_w (
        .clk(clk), .rst(s_rst), .Done(s_done), .results_in(s_res), .got_data(s_got),
        .ready_for_input(s_rfi), .Bus_out(s_bus), .buffer_ready(s_br),
        .empty_buffer(s_empty), .last_beat(s_last), .overflow(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        done;
        logic [31:0] res;
        logic        got;
        logic [7:0]  bus;
        logic        br;
        logic        last;
        logic        empty;
        logic        rfi;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] exp_q[$];

    function automatic vec_t mk(input logic r, input logic d, input logic [31:0] rs, input logic g,
                                input logic [7:0] b, input logic rd, input logic l,
                                input logic e, input logic fi, input logic o);
        vec_t v;
        v.rst = r; v.done = d; v.res = rs; v.got = g;
        v.bus = b; v.br = rd; v.last = l; v.empty = e; v.rfi = fi; v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sw_word(input int t, input int i);
        return {8'(t), 8'(i), 16'h5A00 + 16'(t * 16 + i)};
    endfunction

    task automatic sw_load(input int t);
        for (int i = 0; i < 3; i++) begin
            s_res[i*32 +: 32] = sw_word(t, i);
            exp_q.push_back(sw_word(t, i) >> 16);
            exp_q.push_back(sw_word(t, i) & 32'hFFFF);
        end
    endtask

    initial begin
        int pushed, received, cycles;
        rst = 1'b1; done = 1'b0; got = 1'b0; res = '0;
        s_rst = 1'b1; s_done = 1'b0; s_got = 1'b0; s_res = '0;

        //           rst done res           got  bus   br last emp rfi ovf
        vecs.push_back(mk(0, 1, 32'hABCD1234, 1, 8'h00, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h12, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h34, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'hAB, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'hCD, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h00010002, 0, 8'h00, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h00030004, 0, 8'h00, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h00050006, 0, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h00, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h02, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h00, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h01, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h04, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h03, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 8'h00, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 8'h00, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 32'hA1B2C3D4, 1, 8'h00, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'hC3, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'hD4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'hA1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h55667788, 1, 8'hB2, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 8'h77, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h77, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h88, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 8'h55, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0BADF00D, 1, 8'h00, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'hF0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h0D, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'h0B, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8'hAD, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 8'h00, 0, 0, 1, 1, 0));

        step();
        step();

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].rst; done = vecs[k].done; res = vecs[k].res; got = vecs[k].got;
            chk($sformatf("v%0d bus", k),   32'(bus),   32'(vecs[k].bus));
            chk($sformatf("v%0d ready", k), 32'(br),    32'(vecs[k].br));
            chk($sformatf("v%0d last", k),  32'(last),  32'(vecs[k].last));
            chk($sformatf("v%0d empty", k), 32'(empty), 32'(vecs[k].empty));
            chk($sformatf("v%0d rfi", k),   32'(rfi),   32'(vecs[k].rfi));
            chk($sformatf("v%0d ovf", k),   32'(ovf),   32'(vecs[k].ovf));
            step();
        end

        // Stall after the second beat
        rst = 1'b0; done = 1'b1; res = 32'hABCD1234; got = 1'b0;
        step();
        done = 1'b0; res = '0;
        chk("stall b0", 32'(bus), 32'h12);
        got = 1'b1;
        step();
        chk("stall b1", 32'(bus), 32'h34);
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall hold%0d bus", i), 32'(bus), 32'h34);
            chk($sformatf("stall hold%0d last", i), 32'(last), 32'h0);
            chk($sformatf("stall hold%0d ready", i), 32'(br), 32'h1);
        end
        got = 1'b1;
        step();
        chk("stall b2", 32'(bus), 32'hAB);
        step();
        chk("stall b3", 32'(bus), 32'hCD);
        chk("stall b3 last", 32'(last), 32'h1);
        step();
        got = 1'b0;
        chk("stall end ready", 32'(br), 32'h0);
        chk("stall end empty", 32'(empty), 32'h1);
        chk("stall end bus", 32'(bus), 32'h0);

        // Wide configuration: fill, then drain with interleaved pushes across pointer wrap
        s_rst = 1'b0;
        step();
        chk("w reset empty", 32'(s_empty), 32'h1);
        for (int t = 0; t < 4; t++) begin
            s_done = 1'b1;
            sw_load(t);
            step();
        end
        s_done = 1'b0;
        chk("w full rfi", 32'(s_rfi), 32'h0);
        chk("w full ready", 32'(s_br), 32'h1);
        pushed = 4; received = 0; cycles = 0;
        while (received < 60 && cycles < 1000) begin
            s_done = 1'b0;
            s_got  = (cycles % 5) != 4;
            if (s_rfi && pushed < 10 && (cycles % 3) == 0) begin
                s_done = 1'b1;
                sw_load(pushed);
                pushed++;
            end
            if (s_br && s_got) begin
                if (exp_q.size() == 0) begin
                    chk("w extra beat", 32'(s_bus), 32'hFFFFFFFF);
                    received = 60;
                end else begin
                    chk($sformatf("w beat%0d", received), 32'(s_bus), 32'(exp_q[0]));
                    chk($sformatf("w last%0d", received), 32'(s_last), 32'((received % 6) == 5));
                    void'(exp_q.pop_front());
                    received++;
                end
            end
            step();
            cycles++;
        end
        s_done = 1'b0; s_got = 1'b0;
        chk("w received", 32'(received), 32'd60);
        chk("w pushed", 32'(pushed), 32'd10);
        chk("w drained empty", 32'(s_empty), 32'h1);
        chk("w drained ready", 32'(s_br), 32'h0);
        chk("w overflow", 32'(s_ovf), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
